alu_issue_ctrl: RTL and testbench

Multi-cycle instruction issue/decode controller that drives the 16-bit ALU (A, B, Opcode, cin in; C, Flags out). It accepts one 16-bit instruction word over a valid/ready handshake and reads operands from a synchronous-read register file. It sequences the ALU, writes the result back and maintains the processor status register (PSR) whose carry bit feeds the ALU carry-in.

---
 rtl/alu_issue_ctrl.sv | 176 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue/decode controller for the 16-bit ALU.
//
// Accepts one instruction word over a valid/ready handshake. It then reads the
// dest/src operands from a synchronous-read register file and presents
// registered operands and an opcode to the ALU. The result is written back and
// the processor status register (PSR) is updated. One instruction retires
// every four cycles: accept, READ, EXEC, WB.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   inst_valid/inst_ready   instruction handshake, inst is the 16-bit word
//   rf_raddr_a/_b           regfile read addresses (dest, src)
//   rf_rdata_a/_b           regfile read data, valid one cycle after address
//   alu_a/alu_b/alu_opcode  registered ALU inputs
//   alu_cin                 ALU carry-in, the PSR carry bit
//   alu_c/alu_flags         ALU result and flags {Z,C,F,N,L}
//   rf_we/rf_waddr/rf_wdata regfile write port, one-cycle pulse in WB
//   psr                     status register {Z,C,F,N,L}
//   done/illegal            retire pulse, illegal-opcode pulse with done
module alu_issue_ctrl #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int IMM_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [15:0]       inst,
    output logic [REG_AW-1:0] rf_raddr_a,
    output logic [REG_AW-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_opcode,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_c,
    input  logic [4:0]        alu_flags,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [4:0]        psr,
    output logic              done,
    output logic              illegal
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] EXEC = 2'd2;
    localparam logic [1:0] WB   = 2'd3;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LSH  = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_ADDU = 4'h6;
    localparam logic [3:0] OP_ADDC = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_SUB  = 4'h9;
    localparam logic [3:0] OP_SUBC = 4'hA;
    localparam logic [3:0] OP_CMP  = 4'hB;
    localparam logic [3:0] OP_ASHU = 4'hC;

    function automatic logic signed [DATA_W-1:0] sign_ext(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    // Everything above ASHU is unassigned encoding space.
    function automatic logic op_illegal(input logic [3:0] op);
        return op > OP_ASHU;
    endfunction

    function automatic logic op_writes(input logic [3:0] op);
        return !(op == OP_NOP || op == OP_CMP || op_illegal(op));
    endfunction

    // Only arithmetic and compare results are allowed to touch the PSR.
    function automatic logic op_sets_psr(input logic [3:0] op);
        logic hit;
        hit = 1'b0;
        case (op)
            OP_ADD, OP_ADDU, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Shifts take the amount on A and the value on B; NOT works on A.
    // All of these put src on A and dest on B.
    function automatic logic op_swaps(input logic [3:0] op);
        return (op == OP_LSH) || (op == OP_ASHU) || (op == OP_NOT);
    endfunction

    logic [1:0]               state;
    logic [15:0]              inst_p0;
    logic signed [DATA_W-1:0] alu_a_p1;
    logic signed [DATA_W-1:0] alu_b_p1;
    logic [3:0]               alu_op_p1;
    logic [4:0]               psr_q;

    logic [3:0]               op;
    logic [REG_AW-1:0]        rdest;
    logic [REG_AW-1:0]        rsrc;
    logic signed [DATA_W-1:0] src_opd;
    logic signed [DATA_W-1:0] dest_opd;
    logic                     in_wb;

    assign op       = inst_p0[15:12];
    assign rdest    = inst_p0[8 +: REG_AW];
    assign rsrc     = inst_p0[0 +: REG_AW];
    assign src_opd  = inst_p0[7] ? sign_ext(inst_p0[IMM_W-1:0]) : $signed(rf_rdata_b);
    assign dest_opd = $signed(rf_rdata_a);

    // The latched word holds still through READ, so the regfile addresses
    // can come straight from it.
    assign rf_raddr_a = rdest;
    assign rf_raddr_b = rsrc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            inst_p0   <= '0;
            alu_a_p1  <= '0;
            alu_b_p1  <= '0;
            alu_op_p1 <= OP_NOP;
            psr_q     <= '0;
        end else begin
            case (state)
                // Stage 0: capture the instruction word on the handshake
                IDLE: begin
                    if (inst_valid) begin
                        inst_p0 <= inst;
                        state   <= READ;
                    end
                end
                // Regfile addresses are presented; data arrives next cycle
                READ: state <= EXEC;
                // Stage 1: register ALU operands and opcode
                EXEC: begin
                    if (op_swaps(op)) begin
                        alu_a_p1 <= src_opd;
                        alu_b_p1 <= dest_opd;
                    end else begin
                        alu_a_p1 <= dest_opd;
                        alu_b_p1 <= src_opd;
                    end
                    alu_op_p1 <= op_illegal(op) ? OP_NOP : op;
                    state     <= WB;
                end
                // Stage 2: retire, the ALU result is consumed combinationally
                WB: begin
                    if (op_sets_psr(op)) begin
                        psr_q <= alu_flags;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_wb      = (state == WB);
    assign inst_ready = (state == IDLE);
    assign done       = in_wb;
    assign illegal    = in_wb && op_illegal(op);
    assign rf_we      = in_wb && op_writes(op);
    assign rf_waddr   = rf_we ? rdest : '0;
    assign rf_wdata   = rf_we ? alu_c : '0;

    assign alu_a      = alu_a_p1;
    assign alu_b      = alu_b_p1;
    assign alu_opcode = alu_op_p1;
    assign psr        = psr_q;
    assign alu_cin    = psr_q[3];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl. It provides a synchronous-read register file and
// a behavioural ALU around the controller. A per-instruction outcome model is
// checked against the DUT outputs every cycle, alongside hand-computed
// expectations for the directed vectors.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [15:0] inst = '0;
    logic [3:0]  rf_raddr_a, rf_raddr_b;
    logic [15:0] rf_rdata_a, rf_rdata_b;
    logic [15:0] alu_a, alu_b, alu_c;
    logic [3:0]  alu_opcode;
    logic        alu_cin;
    logic [4:0]  alu_flags;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [4:0]  psr;
    logic        done, illegal;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(16), .REG_AW(4), .IMM_W(7)) dut (
        .clk(clk), .reset(reset),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
        .alu_c(alu_c), .alu_flags(alu_flags),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .psr(psr), .done(done), .illegal(illegal)
    );

    // ALU behaviour: returns {Z,C,F,N,L, result}. CMP sets L when src < dest
    // unsigned and N when src < dest signed (A = dest, B = src).
    function automatic logic [20:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] op, input logic cin);
        logic [16:0]        s;
        logic [15:0]        r;
        logic signed [15:0] sb;
        logic               z, c, f, n, l;
        int                 sh;
        s = '0; r = '0; c = 1'b0; f = 1'b0; n = 1'b0; l = 1'b0;
        sb = b;
        sh = int'($signed(a));
        case (op)
            4'h1: r = a & b;
            4'h2: r = a | b;
            4'h3: r = a ^ b;
            4'h4: r = (sh >= 0) ? (b << sh) : (b >> (-sh));
            4'hC: r = (sh >= 0) ? (b << sh) : 16'(sb >>> (-sh));
            4'h5, 4'h6, 4'h7: begin
                s = {1'b0, a} + {1'b0, b} + {16'b0, (op == 4'h7) & cin};
                r = s[15:0];
                c = s[16];
                if (op != 4'h6) begin
                    f = (a[15] == b[15]) && (r[15] != a[15]);
                    n = r[15];
                end
            end
            4'h8: r = ~a;
            4'h9, 4'hA: begin
                s = {1'b0, a} - {1'b0, b} - {16'b0, (op == 4'hA) & cin};
                r = s[15:0];
                c = s[16];
                f = (a[15] != b[15]) && (r[15] != a[15]);
                n = r[15];
            end
            4'hB: begin
                r = a - b;
                n = (sb < $signed(a));
                l = (b < a);
            end
            default: r = '0;
        endcase
        z = (op == 4'hB) ? (a == b) : (r == '0);
        return {z, c, f, n, l, r};
    endfunction

    logic [20:0] alu_out;
    assign alu_out   = alu_fn(alu_a, alu_b, alu_opcode, alu_cin);
    assign alu_flags = alu_out[20:16];
    assign alu_c     = alu_out[15:0];

    // Register file: synchronous read, DUT write port plus a bench preload port.
    logic [15:0] rf [16];
    logic        bd_we = 1'b0;
    logic [3:0]  bd_addr = '0;
    logic [15:0] bd_data = '0;

    always @(posedge clk) begin
        rf_rdata_a <= rf[rf_raddr_a];
        rf_rdata_b <= rf[rf_raddr_b];
        if (rf_we) rf[rf_waddr] <= rf_wdata;
        if (bd_we) rf[bd_addr] <= bd_data;
    end

    // Outcome model: one record per accepted instruction, applied at retire.
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic        we;
        logic [3:0]  waddr;
        logic [15:0] wdata;
        logic        psr_upd;
        logic [4:0]  flags;
        logic        ill;
        logic [3:0]  ra;
        logic [3:0]  rb;
    } exp_t;

    function automatic exp_t predict(input logic [15:0] w, input logic [15:0] dv,
                                     input logic [15:0] sv, input logic cin);
        exp_t        e;
        logic [3:0]  op;
        logic [15:0] src;
        logic [20:0] res;
        op    = w[15:12];
        src   = w[7] ? {{9{w[6]}}, w[6:0]} : sv;
        e.ill = (op > 4'hC);
        e.op  = e.ill ? 4'h0 : op;
        if (op == 4'h4 || op == 4'hC || op == 4'h8) begin
            e.a = src; e.b = dv;
        end else begin
            e.a = dv;  e.b = src;
        end
        res       = alu_fn(e.a, e.b, e.op, cin);
        e.flags   = res[20:16];
        e.wdata   = res[15:0];
        e.we      = !(op == 4'h0 || op == 4'hB || e.ill);
        e.waddr   = w[11:8];
        e.psr_upd = (op inside {4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB});
        e.ra      = w[11:8];
        e.rb      = w[3:0];
        return e;
    endfunction

    exp_t        ex;
    int          busy = 0;          // cycles since acceptance, 0 = idle
    logic [4:0]  m_psr = '0;
    logic [15:0] m_rf [16];

    always @(posedge clk) begin
        if (bd_we) m_rf[bd_addr] <= bd_data;
        if (reset) begin
            busy  <= 0;
            m_psr <= '0;
        end else if (busy == 0) begin
            if (inst_valid) begin
                ex   <= predict(inst, m_rf[inst[11:8]], m_rf[inst[3:0]], m_psr[3]);
                busy <= 1;
            end
        end else if (busy == 3) begin
            if (ex.we) m_rf[ex.waddr] <= ex.wdata;
            if (ex.psr_upd) m_psr <= ex.flags;
            busy <= 0;
        end else begin
            busy <= busy + 1;
        end
    end

    int n_chk = 0;
    int n_err = 0;
    logic stop = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic compare_cycle();
        logic wb;
        wb = (busy == 3);
        chk("inst_ready", 32'(inst_ready), 32'(busy == 0));
        chk("done", 32'(done), 32'(wb));
        chk("illegal", 32'(illegal), 32'(wb && ex.ill));
        chk("rf_we", 32'(rf_we), 32'(wb && ex.we));
        chk("psr", 32'(psr), 32'(m_psr));
        chk("alu_cin", 32'(alu_cin), 32'(m_psr[3]));
        if (busy == 1) begin
            chk("rf_raddr_a", 32'(rf_raddr_a), 32'(ex.ra));
            chk("rf_raddr_b", 32'(rf_raddr_b), 32'(ex.rb));
        end
        if (wb) begin
            chk("alu_opcode", 32'(alu_opcode), 32'(ex.op));
            if (!ex.ill) begin
                chk("alu_a", 32'(alu_a), 32'(ex.a));
                chk("alu_b", 32'(alu_b), 32'(ex.b));
            end
            if (ex.we) begin
                chk("rf_waddr", 32'(rf_waddr), 32'(ex.waddr));
                chk("rf_wdata", 32'(rf_wdata), 32'(ex.wdata));
            end
        end
    endtask

    // Values seen in the WB cycle of the last instruction run.
    logic        cap_we, cap_ill, cap_cin;
    logic [3:0]  cap_waddr, cap_op;
    logic [15:0] cap_wdata, cap_a, cap_b;
    int          lat;
    logic [4:0]  psr_before;

    task automatic set_reg(input logic [3:0] r, input logic [15:0] v);
        bd_we = 1'b1; bd_addr = r; bd_data = v;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Issue one instruction and stop on the negedge after it retires.
    task automatic run(input logic [15:0] w);
        int k;
        k = 0;
        while (!inst_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        inst = w; inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        lat = 1;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        cap_we = rf_we; cap_waddr = rf_waddr; cap_wdata = rf_wdata;
        cap_a = alu_a; cap_b = alu_b; cap_op = alu_opcode;
        cap_cin = alu_cin; cap_ill = illegal;
        chk("latency", 32'(lat), 32'd3);
        @(negedge clk);
    endtask

    task automatic sequence_run();
        logic [15:0] extras [6];
        int          pulses;
        extras = '{16'h1182, 16'h2283, 16'h3384, 16'h8580, 16'h9102, 16'hA1FF};

        set_reg(4'd0, 16'h0000);
        set_reg(4'd1, 16'h7FFF);
        set_reg(4'd2, 16'h0001);
        run(16'h5102);
        chk("add_we", 32'(cap_we), 32'd1);
        chk("add_waddr", 32'(cap_waddr), 32'd1);
        chk("add_wdata", 32'(cap_wdata), 32'h8000);
        chk("add_psr", 32'(psr), 32'b00110);
        chk("add_ready_c4", 32'(inst_ready), 32'd1);

        set_reg(4'd3, 16'hFFFF);
        run(16'h6381);
        chk("addu_wdata", 32'(cap_wdata), 32'h0000);
        chk("addu_psr", 32'(psr), 32'b11000);
        set_reg(4'd4, 16'h0000);
        run(16'h7400);
        chk("addc_cin", 32'(cap_cin), 32'd1);
        chk("addc_wdata", 32'(cap_wdata), 32'h0001);

        psr_before = psr;
        set_reg(4'd5, 16'h8001);
        run(16'h45FF);
        chk("lsh_a", 32'(cap_a), 32'hFFFF);
        chk("lsh_b", 32'(cap_b), 32'h8001);
        chk("lsh_wdata", 32'(cap_wdata), 32'h4000);
        chk("lsh_psr", 32'(psr), 32'(psr_before));
        set_reg(4'd5, 16'h8001);
        run(16'hC5FF);
        chk("ashu_wdata", 32'(cap_wdata), 32'hC000);
        chk("ashu_psr", 32'(psr), 32'(psr_before));

        foreach (extras[i]) run(extras[i]);

        set_reg(4'd6, 16'hFFFE);
        set_reg(4'd7, 16'h0001);
        run(16'hB607);
        chk("cmp_we", 32'(cap_we), 32'd0);
        chk("cmp_psr_l", 32'(psr[0]), 32'd1);
        chk("cmp_psr_z", 32'(psr[4]), 32'd0);
        psr_before = psr;
        run(16'h0000);
        chk("nop_we", 32'(cap_we), 32'd0);
        chk("nop_psr", 32'(psr), 32'(psr_before));

        run(16'hE123);
        chk("ill_opcode", 32'(cap_op), 32'h0);
        chk("ill_flag", 32'(cap_ill), 32'd1);
        chk("ill_we", 32'(cap_we), 32'd0);
        chk("ill_psr", 32'(psr), 32'(psr_before));

        // Abandon an ADD with a one-cycle reset during EXEC.
        set_reg(4'd1, 16'h0010);
        set_reg(4'd2, 16'h0003);
        inst = 16'h5102; inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", 32'(inst_ready), 32'd1);
        chk("rst_psr", 32'(psr), 32'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (done || rf_we) pulses++;
            @(negedge clk);
        end
        chk("rst_no_pulses", 32'(pulses), 32'd0);
        run(16'h5102);
        chk("post_rst_wdata", 32'(cap_wdata), 32'h0013);
        chk("post_rst_psr", 32'(psr), 32'd0);

        repeat (2) @(negedge clk);
        stop = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(inst_ready), 32'd1);
        chk("reset_psr", 32'(psr), 32'd0);
        chk("reset_alu_a", 32'(alu_a), 32'd0);
        chk("reset_alu_b", 32'(alu_b), 32'd0);
        chk("reset_opcode", 32'(alu_opcode), 32'd0);
        chk("reset_we", 32'(rf_we), 32'd0);
        chk("reset_waddr", 32'(rf_waddr), 32'd0);
        chk("reset_wdata", 32'(rf_wdata), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        reset = 1'b0;
        fork
            begin
                while (!stop) begin
                    @(negedge clk);
                    if (!stop) compare_cycle();
                end
            end
            sequence_run();
        join
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
